// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the PC register / fetch-control stage.
package pc_fetch_unit_pkg;

  localparam int          XLEN_DEF      = 32;
  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;

  // Next-PC select as produced by PC_sel_gen
  typedef enum logic [1:0] {
    PC_SEL_SEQ  = 2'b00,
    PC_SEL_BR   = 2'b01,
    PC_SEL_JALR = 2'b10,
    PC_SEL_SYS  = 2'b11
  } pc_sel_e;

  // Fetch-control FSM states
  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } fetch_state_e;

  // Branch/JAL and JALR are the only selects that redirect the fetch stream
  function automatic logic is_redirect(input pc_sel_e sel);
    return (sel == PC_SEL_BR) || (sel == PC_SEL_JALR);
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Bundle of select/target/control inputs and PC/status outputs of the fetch stage.
interface pc_fetch_unit_if #(
  parameter int XLEN = 32
);
  logic [1:0]      pc_sel_src;
  logic [XLEN-1:0] branch_target;
  logic [XLEN-1:0] jalr_base;
  logic [XLEN-1:0] jalr_imm;
  logic            sys_halt;
  logic            stall;
  logic            resume;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic            fetch_valid;
  logic            flush;
  logic            halted;
  logic            misaligned;

  // Upstream side: decode / hazard logic drives selects and targets
  modport master (
    output pc_sel_src, branch_target, jalr_base, jalr_imm,
           sys_halt, stall, resume,
    input  pc, pc_plus4, fetch_valid, flush, halted, misaligned
  );

  // Fetch stage side
  modport slave (
    input  pc_sel_src, branch_target, jalr_base, jalr_imm,
           sys_halt, stall, resume,
    output pc, pc_plus4, fetch_valid, flush, halted, misaligned
  );
endinterface

// File: rtl/pc_fetch_unit_next_mux.sv
// Combinational next-PC datapath: pc+4, masked JALR target, selected
// next PC and the word-misalignment flag for redirects.
module pc_next_mux
  import pc_fetch_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [1:0]      pc_sel_src,
  input  logic [XLEN-1:0] branch_target,
  input  logic [XLEN-1:0] jalr_base,
  input  logic [XLEN-1:0] jalr_imm,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] jalr_target,
  output logic [XLEN-1:0] next_pc,
  output logic            redirect,
  output logic            misalign
);

  localparam logic [XLEN-1:0] FOUR     = XLEN'(4);
  localparam logic [XLEN-1:0] BIT0_CLR = ~XLEN'(1);

  pc_sel_e sel;

  // Select decode, adders (wrap modulo 2^XLEN) and target mux
  always_comb begin
    sel         = pc_sel_e'(pc_sel_src);
    pc_plus4    = pc + FOUR;
    jalr_target = (jalr_base + jalr_imm) & BIT0_CLR;
    redirect    = is_redirect(sel);
    next_pc     = pc_plus4;
    unique case (sel)
      PC_SEL_SEQ:  next_pc = pc_plus4;
      PC_SEL_BR:   next_pc = branch_target;
      PC_SEL_JALR: next_pc = jalr_target;
      PC_SEL_SYS:  next_pc = pc_plus4;
      default:     next_pc = pc_plus4;
    endcase
    // Bit 0 is ignored (already cleared for JALR); bit 1 set means not word aligned
    misalign = redirect && next_pc[1];
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and fetch-control FSM: stall hold, one-cycle flush after a
// redirect, halt on ECALL/EBREAK and a sticky misaligned-target trap.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_BOOT | first cycle after reset, no valid fetch, pc = reset vector
// ST_RUN  | fetching; pc advances per select unless stalled
// ST_HALT | fetch stopped; resume leaves unless the trap flag is set
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEF)
) (
  input logic            clk,
  input logic            rst,
  pc_fetch_unit_if.slave bus
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            flush_q, flush_d;
  logic            misaligned_q, misaligned_d;

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] jalr_target;
  logic [XLEN-1:0] next_pc;
  logic            redirect;
  logic            misalign;

  pc_next_mux #(
    .XLEN(XLEN)
  ) u_next_mux (
    .pc            (pc_q),
    .pc_sel_src    (bus.pc_sel_src),
    .branch_target (bus.branch_target),
    .jalr_base     (bus.jalr_base),
    .jalr_imm      (bus.jalr_imm),
    .pc_plus4      (pc_plus4),
    .jalr_target   (jalr_target),
    .next_pc       (next_pc),
    .redirect      (redirect),
    .misalign      (misalign)
  );

  // Next-state and next-register values; flush defaults low so it only
  // ever lasts the single cycle after an accepted redirect
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    flush_d      = 1'b0;
    misaligned_d = misaligned_q;
    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (!bus.stall) begin
          if (redirect) begin
            if (misalign) begin
              misaligned_d = 1'b1;
              state_d      = ST_HALT;
            end else begin
              pc_d    = next_pc;
              flush_d = 1'b1;
            end
          end else if ((pc_sel_e'(bus.pc_sel_src) == PC_SEL_SYS) && bus.sys_halt) begin
            state_d = ST_HALT;
          end else begin
            pc_d = next_pc;
          end
        end
      end
      ST_HALT: begin
        // A misaligned trap is only cleared by reset
        if (bus.resume && !misaligned_q) begin
          state_d = ST_RUN;
          pc_d    = pc_plus4;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  // State and PC registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_VEC;
      flush_q      <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      flush_q      <= flush_d;
      misaligned_q <= misaligned_d;
    end
  end

  // Output mapping
  always_comb begin
    bus.pc          = pc_q;
    bus.pc_plus4    = pc_plus4;
    bus.fetch_valid = (state_q == ST_RUN);
    bus.flush       = flush_q;
    bus.halted      = (state_q == ST_HALT);
    bus.misaligned  = misaligned_q;
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed plus randomized check of pc_fetch_unit against a cycle-level
// behavioural model of the fetch stage.
module tb_pc_fetch_unit;

  logic clk;
  logic rst;

  pc_fetch_unit_if #(.XLEN(32)) ifc ();

  pc_fetch_unit #(
    .XLEN      (32),
    .RESET_VEC (32'h0000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: mode 0=boot 1=running 2=halted
  localparam int M_BOOT = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic [31:0] m_pc;
  int          m_mode;
  logic        m_flush;
  logic        m_mis;

  logic [31:0] n_pc;
  int          n_mode;
  logic        n_flush;
  logic        n_mis;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compute what the stage should hold after the coming edge
  task automatic model_step();
    logic [31:0] tgt;
    n_pc    = m_pc;
    n_mode  = m_mode;
    n_flush = 1'b0;
    n_mis   = m_mis;
    if (rst === 1'b0) begin
      n_pc   = 32'h0;
      n_mode = M_BOOT;
      n_mis  = 1'b0;
    end else if (m_mode == M_BOOT) begin
      n_mode = M_RUN;
    end else if (m_mode == M_HALT) begin
      if (ifc.resume && !m_mis) begin
        n_mode = M_RUN;
        n_pc   = m_pc + 32'd4;
      end
    end else if (!ifc.stall) begin
      if (ifc.pc_sel_src == 2'd1 || ifc.pc_sel_src == 2'd2) begin
        if (ifc.pc_sel_src == 2'd1) tgt = ifc.branch_target;
        else tgt = (ifc.jalr_base + ifc.jalr_imm) & 32'hFFFF_FFFE;
        if ((tgt % 4) >= 2) begin
          n_mis  = 1'b1;
          n_mode = M_HALT;
        end else begin
          n_pc    = tgt;
          n_flush = 1'b1;
        end
      end else if (ifc.pc_sel_src == 2'd3 && ifc.sys_halt) begin
        n_mode = M_HALT;
      end else begin
        n_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},          ifc.pc,          m_pc);
    chk({tag, ".pc_plus4"},    ifc.pc_plus4,    m_pc + 32'd4);
    chk({tag, ".fetch_valid"}, 32'(ifc.fetch_valid), 32'(m_mode == M_RUN));
    chk({tag, ".flush"},       32'(ifc.flush),  32'(m_flush));
    chk({tag, ".halted"},      32'(ifc.halted), 32'(m_mode == M_HALT));
    chk({tag, ".misaligned"},  32'(ifc.misaligned), 32'(m_mis));
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    m_pc    = n_pc;
    m_mode  = n_mode;
    m_flush = n_flush;
    m_mis   = n_mis;
    check_all(tag);
  endtask

  task automatic set_in(input logic [1:0] sel, input logic [31:0] bt,
                        input logic [31:0] jb, input logic [31:0] ji,
                        input logic sh, input logic st, input logic rs);
    ifc.pc_sel_src    = sel;
    ifc.branch_target = bt;
    ifc.jalr_base     = jb;
    ifc.jalr_imm      = ji;
    ifc.sys_halt      = sh;
    ifc.stall         = st;
    ifc.resume        = rs;
  endtask

  initial begin
    m_pc = 32'h0; m_mode = M_BOOT; m_flush = 1'b0; m_mis = 1'b0;
    rst = 1'b0;
    set_in(2'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Reset release, sequential fetch from the reset vector
    tick("rst");
    chk("boot.fv", 32'(ifc.fetch_valid), 32'd0);
    chk("boot.pc", ifc.pc, 32'h0);
    rst = 1'b1;
    tick("seq0");
    chk("seq0.pc", ifc.pc, 32'h0);
    chk("seq0.fv", 32'(ifc.fetch_valid), 32'd1);
    tick("seq1");
    chk("seq1.pc", ifc.pc, 32'h4);
    tick("seq2");
    chk("seq2.pc", ifc.pc, 32'h8);
    chk("seq2.flush", 32'(ifc.flush), 32'd0);

    // Branch 0x10 -> 0x40 then sequential
    set_in(2'd1, 32'h10, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick("br_a");
    set_in(2'd1, 32'h40, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick("br_b");
    chk("br.pc", ifc.pc, 32'h40);
    chk("br.flush", 32'(ifc.flush), 32'd1);
    set_in(2'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick("br_seq");
    chk("br_seq.pc", ifc.pc, 32'h44);
    chk("br_seq.flush", 32'(ifc.flush), 32'd0);

    // JALR with bit 0 masked, then misaligned JALR trap
    set_in(2'd2, 32'h0, 32'h101, 32'h4, 1'b0, 1'b0, 1'b0);
    tick("jalr_ok");
    chk("jalr.pc", ifc.pc, 32'h104);
    chk("jalr.flush", 32'(ifc.flush), 32'd1);
    set_in(2'd2, 32'h0, 32'h102, 32'h0, 1'b0, 1'b0, 1'b0);
    tick("jalr_mis");
    chk("mis.flag", 32'(ifc.misaligned), 32'd1);
    chk("mis.halted", 32'(ifc.halted), 32'd1);
    chk("mis.pc", ifc.pc, 32'h104);
    set_in(2'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    tick("mis_resume");
    chk("mis_resume.halted", 32'(ifc.halted), 32'd1);
    set_in(2'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick("mis_rst");
    chk("mis_rst.flag", 32'(ifc.misaligned), 32'd0);
    rst = 1'b1;
    tick("mis_boot");

    // Stall holds over a pending branch
    set_in(2'd1, 32'h20, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick("st_pre");
    set_in(2'd1, 32'h80, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick("stall");
      chk("stall.pc", ifc.pc, 32'h20);
      chk("stall.flush", 32'(ifc.flush), 32'd0);
    end
    ifc.stall = 1'b0;
    tick("st_rel");
    chk("st_rel.pc", ifc.pc, 32'h80);
    chk("st_rel.flush", 32'(ifc.flush), 32'd1);

    // ECALL halt, resume, SYSTEM as NOP
    set_in(2'd1, 32'h30, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick("sys_pre");
    set_in(2'd3, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    tick("sys_halt");
    chk("sys_halt.halted", 32'(ifc.halted), 32'd1);
    chk("sys_halt.fv", 32'(ifc.fetch_valid), 32'd0);
    chk("sys_halt.pc", ifc.pc, 32'h30);
    set_in(2'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    tick("sys_resume");
    chk("sys_resume.pc", ifc.pc, 32'h34);
    chk("sys_resume.fv", 32'(ifc.fetch_valid), 32'd1);
    set_in(2'd3, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick("sys_nop");
    chk("sys_nop.pc", ifc.pc, 32'h38);
    chk("sys_nop.halted", 32'(ifc.halted), 32'd0);

    // Wraparound, then reset while halted
    set_in(2'd1, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick("wrap_pre");
    set_in(2'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick("wrap");
    chk("wrap.pc", ifc.pc, 32'h0);
    set_in(2'd3, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    tick("halt_pre");
    rst = 1'b0;
    set_in(2'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    tick("halt_rst");
    chk("halt_rst.pc", ifc.pc, 32'h0);
    chk("halt_rst.halted", 32'(ifc.halted), 32'd0);
    chk("halt_rst.fv", 32'(ifc.fetch_valid), 32'd0);
    rst = 1'b1;

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [31:0] bt, jb, ji;
      bt = $urandom;
      jb = $urandom;
      ji = $urandom_range(0, 64);
      if ($urandom_range(0, 7) != 0) bt = bt & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) != 0) begin
        jb = jb & 32'hFFFF_FFFC;
        ji = ji & 32'hFFFF_FFFC;
      end
      set_in(2'($urandom_range(0, 3)), bt, jb, ji,
             ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 25),
             ($urandom_range(0, 99) < 30));
      rst = ($urandom_range(0, 99) < 4) ? 1'b0 : 1'b1;
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter register and fetch-control stage of femtoRV32.
- Sits directly downstream of PC_sel_gen: consumes its 2-bit pc_sel_src and the branch/JAL/JALR target operands, and produces the PC presented to instruction memory.
- Owns stall hold, one-cycle redirect flush, halt on ECALL/EBREAK, and a sticky misaligned-target trap.

Parameters:
- XLEN, 32, datapath and PC width.
- RESET_VEC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous, active-low reset; sampled on rising clk.
- pc_sel_src  in  2  next-PC select from PC_sel_gen: 00 sequential, 01 branch/JAL, 10 JALR, 11 SYSTEM.
- branch_target  in  XLEN  pc+imm target for branch/JAL.
- jalr_base  in  XLEN  rs1 value for JALR.
- jalr_imm  in  XLEN  sign-extended I-immediate for JALR.
- sys_halt  in  1  decoded ECALL/EBREAK; qualifies pc_sel_src==11.
- stall  in  1  hold PC this cycle (hazard/memory wait).
- resume  in  1  single-cycle pulse to leave HALT.
- pc  out  XLEN  current fetch address (registered).
- pc_plus4  out  XLEN  pc+4, combinational, used as link value.
- fetch_valid  out  1  pc is a valid fetch this cycle.
- flush  out  1  registered; high one cycle after an accepted redirect.
- halted  out  1  state==HALT.
- misaligned  out  1  sticky trap flag.

Behaviour:
- Reset (rst==0 at a rising edge) overrides everything, including mid-redirect or HALT:
  - pc=RESET_VEC, state=BOOT.
  - fetch_valid=0, flush=0, halted=0, misaligned=0.
- States: BOOT, RUN, HALT.
- BOOT:
  - fetch_valid=0; pc held.
  - Unconditionally goes to RUN on the next edge; stall is ignored.
  - First valid fetch is at RESET_VEC, one cycle after reset release.
- RUN: fetch_valid=1.
  - If stall: pc, state and flags hold; flush is driven 0 next edge. Stall has priority over every select value, including halt entry.
  - Else, by pc_sel_src:
    - 00: pc<=pc+4.
    - 01: pc<=branch_target.
    - 10: pc<=(jalr_base+jalr_imm) & ~1.
    - 11 with sys_halt=1: pc holds, state<=HALT.
    - 11 with sys_halt=0 (FENCE/CSR as NOP): pc<=pc+4.
  - Redirect (01 or 10, not stalled):
    - If computed target[1] != 0 (bit 0 already cleared for JALR; branch bit0 ignored): misaligned<=1, state<=HALT, pc holds, flush<=0.
    - Otherwise flush<=1 for exactly the next cycle.
  - flush is 0 on every other edge.
- HALT: fetch_valid=0, halted=1, pc holds.
  - resume=1 and misaligned=0: state<=RUN, pc<=pc+4, i.e. the instruction after ECALL/EBREAK.
  - resume while misaligned=1 is ignored; only reset exits.
- Arithmetic:
  - All adds are modulo 2^XLEN, with no overflow detection.
  - pc=32'hFFFF_FFFC sequential -> 32'h0000_0000.
- Latency: select and targets are sampled at edge N; the new pc is visible after edge N; flush is high during cycle N+1.
- Inputs are don't-care in BOOT/HALT, except resume in HALT.

Decomposition:
- Constants go in defines.v:
  - PC_SEL_SEQ=2'b00, PC_SEL_BR=2'b01, PC_SEL_JALR=2'b10, PC_SEL_SYS=2'b11.
  - State codes ST_BOOT, ST_RUN, ST_HALT.
  - RESET_VEC default.
- One combinational sub-module, pc_next_mux: computes pc+4, the masked JALR target, the selected next-PC and the misalign flag.
- The top holds the FSM and registers.

Test Plan:
- Reset release, all inputs 0: cycle 0 fetch_valid=0, pc=0; then pc=0,4,8 with fetch_valid=1, flush=0.
- pc=0x10, sel=01, branch_target=0x40: next pc=0x40, flush=1 for one cycle, then sequential 0x44.
- sel=10, jalr_base=0x101, jalr_imm=0x4 -> pc=0x104 with flush=1. Second case: jalr_base=0x102, jalr_imm=0 -> misaligned=1, halted=1, pc unchanged; resume has no effect, reset clears it.
- pc=0x20, stall=1 for 3 cycles with sel=01: pc stays 0x20, flush=0. Stall drops with sel=01, target=0x80 -> pc=0x80 and flush=1.
- pc=0x30, sel=11, sys_halt=1: halted=1, fetch_valid=0, pc=0x30. Resume pulse -> RUN, pc=0x34. Then sel=11, sys_halt=0 -> pc=0x38 with no halt.
- pc=0xFFFF_FFFC, sel=00 -> pc=0. Also assert rst=0 while in HALT -> pc=RESET_VEC, all flags 0, state BOOT.
